// File: rtl/tlc_pkg.sv
// Shared lamp encodings, direction indices and fault codes for the traffic-light safety monitor.
// Helpers classify lamp values and single-step colour changes.
package tlc_pkg;

    typedef logic [1:0] dir_t;
    typedef logic [2:0] lamp_t;

    localparam lamp_t RED    = 3'b100;
    localparam lamp_t YELLOW = 3'b010;
    localparam lamp_t GREEN  = 3'b001;

    localparam dir_t DIR_N = 2'd0;
    localparam dir_t DIR_E = 2'd1;
    localparam dir_t DIR_S = 2'd2;
    localparam dir_t DIR_W = 2'd3;

    localparam logic [2:0] FLT_NONE        = 3'd0;
    localparam logic [2:0] FLT_ENC         = 3'd1;
    localparam logic [2:0] FLT_CONFLICT    = 3'd2;
    localparam logic [2:0] FLT_SEQ         = 3'd3;
    localparam logic [2:0] FLT_GREEN_TIME  = 3'd4;
    localparam logic [2:0] FLT_YELLOW_TIME = 3'd5;
    localparam logic [2:0] FLT_ALL_RED     = 3'd6;

    typedef enum logic {ARMING, ARMED} trk_state_t;

    function automatic logic lamp_valid(input lamp_t l);
        return (l == RED) || (l == YELLOW) || (l == GREEN);
    endfunction

    function automatic logic bad_step(input lamp_t a, input lamp_t b);
        return ((a == RED) && (b == YELLOW)) ||
               ((a == GREEN) && (b == RED)) ||
               ((a == YELLOW) && (b == GREEN));
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Run-length counter for the active phase with short/long compare against the expected length +/- TOL.
// run holds the length up to the previous sample; long_now flags the current sample reaching LEN+TOL+1.
module tlc_phase_timer #(
    parameter int GLEN = 70,
    parameter int YLEN = 20,
    parameter int TOL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        restart,
    input  logic        prev_yel,
    input  logic        cur_yel,
    output logic [15:0] run,
    output logic        short_end,
    output logic        long_now
);

    logic [15:0] run_cur;

    always_comb begin
        run_cur   = restart ? 16'd1 : ((run == 16'hFFFF) ? run : run + 16'd1);
        short_end = int'(run) < ((prev_yel ? YLEN : GLEN) - TOL);
        long_now  = int'(run_cur) == ((cur_yel ? YLEN : GLEN) + TOL + 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= '0;
        end else if (en) begin
            run <= run_cur;
        end else begin
            run <= '0;
        end
    end

endmodule

// File: rtl/tlc_safety_monitor.sv
// Independent conflict/sequence/timing monitor on the four lamp buses; latches the first fault found.
// Inputs are registered once and checked against the previous sample; outputs move two edges after the inputs.
module tlc_safety_monitor
    import tlc_pkg::*;
#(
    parameter int SEC7       = 70,
    parameter int SEC2       = 20,
    parameter int TOL        = 0,
    parameter int MAX_ALLRED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_N,
    input  logic [2:0]  light_E,
    input  logic [2:0]  light_S,
    input  logic [2:0]  light_W,
    input  logic        clr_fault,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_dir,
    output logic        armed,
    output logic [1:0]  active_dir,
    output logic [15:0] rounds
);

    lamp_t [3:0] s_q, p_q;
    logic        sv_q, pv_q;
    trk_state_t  st_q, st_nx;
    dir_t        act_q, act_nx, nxt;
    logic [15:0] ared_q, ared_cur;

    logic        armed_chk, enc, conflict, seq, any_rg, all_red, det, rnd_inc;
    dir_t        enc_dir, conf_dir, seq_dir, first_rg, det_dir;
    logic [2:0]  det_code;
    logic [3:0]  rg;
    int          nonred;
    lamp_t       ac_p, ac_s;
    logic        t_en, t_restart, t_short, t_long;
    logic [15:0] t_run;

    // pv_q marks p_q as a real sample, so the reset value of red never looks like an R->G
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= {4{RED}};
            p_q  <= {4{RED}};
            sv_q <= 1'b0;
            pv_q <= 1'b0;
        end else begin
            s_q  <= {light_W, light_S, light_E, light_N};
            p_q  <= s_q;
            sv_q <= 1'b1;
            pv_q <= sv_q;
        end
    end

    assign armed_chk = pv_q && (st_q == ARMED);
    assign nxt       = act_q + 2'd1;
    assign ac_p      = p_q[act_q];
    assign ac_s      = s_q[act_q];

    always_comb begin
        enc      = 1'b0;
        enc_dir  = DIR_N;
        conflict = 1'b0;
        conf_dir = DIR_N;
        seq      = 1'b0;
        seq_dir  = DIR_N;
        rg       = '0;
        any_rg   = 1'b0;
        first_rg = DIR_N;
        nonred   = 0;
        for (int d = 3; d >= 0; d--) begin
            rg[d] = pv_q && (p_q[d] == RED) && (s_q[d] == GREEN);
            if (!lamp_valid(s_q[d])) begin
                enc     = 1'b1;
                enc_dir = dir_t'(d);
            end
            if (rg[d]) begin
                any_rg   = 1'b1;
                first_rg = dir_t'(d);
            end
            if (armed_chk && (bad_step(p_q[d], s_q[d]) || (rg[d] && (dir_t'(d) != nxt)))) begin
                seq     = 1'b1;
                seq_dir = dir_t'(d);
            end
        end
        for (int d = 0; d < 4; d++) begin
            if (s_q[d] != RED) begin
                nonred = nonred + 1;
                if (nonred == 2) begin
                    conflict = 1'b1;
                    conf_dir = dir_t'(d);
                end
            end
        end
        all_red = (nonred == 0);
    end

    assign ared_cur = all_red ? ((ared_q == 16'hFFFF) ? ared_q : ared_q + 16'd1) : 16'd0;

    always_comb begin
        det_code = FLT_NONE;
        det_dir  = DIR_N;
        if (enc) begin
            det_code = FLT_ENC;
            det_dir  = enc_dir;
        end else if (conflict) begin
            det_code = FLT_CONFLICT;
            det_dir  = conf_dir;
        end else if (seq) begin
            det_code = FLT_SEQ;
            det_dir  = seq_dir;
        end else if (armed_chk && (((ac_p == GREEN) && (ac_s == YELLOW) && t_short) ||
                                   ((ac_s == GREEN) && t_long))) begin
            det_code = FLT_GREEN_TIME;
            det_dir  = act_q;
        end else if (armed_chk && (((ac_p == YELLOW) && (ac_s == RED) && t_short) ||
                                   ((ac_s == YELLOW) && t_long))) begin
            det_code = FLT_YELLOW_TIME;
            det_dir  = act_q;
        end else if (armed_chk && all_red && (int'(ared_cur) >= MAX_ALLRED + 1)) begin
            det_code = FLT_ALL_RED;
            det_dir  = act_q;
        end
    end

    assign det = (det_code != FLT_NONE);

    // The restart decision must not depend on det, since det reads the timer's compare outputs
    assign t_restart = (st_q == ARMING) || rg[nxt] || (ac_p != ac_s);
    assign t_en      = !det && (armed_chk || ((st_q == ARMING) && any_rg));

    tlc_phase_timer #(
        .GLEN (SEC7),
        .YLEN (SEC2),
        .TOL  (TOL)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (t_en),
        .restart   (t_restart),
        .prev_yel  (ac_p == YELLOW),
        .cur_yel   (ac_s == YELLOW),
        .run       (t_run),
        .short_end (t_short),
        .long_now  (t_long)
    );

    always_comb begin
        st_nx   = st_q;
        act_nx  = act_q;
        rnd_inc = 1'b0;
        if (det) begin
            st_nx = ARMING;
        end else if (st_q == ARMING) begin
            if (any_rg) begin
                st_nx  = ARMED;
                act_nx = first_rg;
            end
        end else if (armed_chk) begin
            if (rg[nxt]) begin
                act_nx = nxt;
            end
            rnd_inc = (act_q == DIR_W) && (ac_p == YELLOW) && (ac_s == RED);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ARMING;
            act_q  <= DIR_N;
            rounds <= '0;
            ared_q <= '0;
        end else begin
            st_q   <= st_nx;
            act_q  <= act_nx;
            ared_q <= (armed_chk && !det) ? ared_cur : 16'd0;
            if (rnd_inc) begin
                rounds <= rounds + 16'd1;
            end
        end
    end

    // A fault detected alongside clr_fault replaces whatever was latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            fault_dir  <= DIR_N;
        end else if (det && (clr_fault || !fault)) begin
            fault      <= 1'b1;
            fault_code <= det_code;
            fault_dir  <= det_dir;
        end else if (clr_fault) begin
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            fault_dir  <= DIR_N;
        end
    end

    assign armed      = (st_q == ARMED);
    assign active_dir = act_q;

endmodule
